// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master round-robin Wishbone arbiter; optional watchdog via WB_BUS_ARBITER_TIMEOUT_EN
module wb_bus_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_w,
    input  logic [SEL_W-1:0]  m0_sel,
    output logic [DATA_W-1:0] m0_dat_r,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_w,
    input  logic [SEL_W-1:0]  m1_sel,
    output logic [DATA_W-1:0] m1_dat_r,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_w,
    output logic [SEL_W-1:0]  s_sel,
    input  logic [DATA_W-1:0] s_dat_r,
    input  logic              s_ack,
    input  logic              s_err,
    output logic [1:0]        o_gnt,
    output logic              o_timeout
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state, state_nx;
    logic last_gnt;
    logic g0, g1, g_stb, expire;
    assign g0 = state == GNT0;
    assign g1 = state == GNT1;
    assign g_stb = (g0 && m0_stb) || (g1 && m1_stb);
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign o_timeout = expire;
    assign o_gnt = {g1, g0};
`ifdef WB_BUS_ARBITER_TIMEOUT_EN
    logic [15:0] wd_cnt;
    assign expire = g_stb && !s_ack && !s_err && wd_cnt == 16'(TIMEOUT - 1);
    // watchdog: counts stalled strobe cycles; every grant change passes through IDLE where g_stb is low
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            wd_cnt <= '0;
        else if (!g_stb || s_ack || s_err || expire)
            wd_cnt <= '0;
        else if (wd_cnt != 16'(TIMEOUT))
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    assign expire = 1'b0;
`endif
    // state register and last-granted master, updated on entry to a grant state
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE)
                last_gnt <= state_nx == GNT1;
        end
    end
    // next-state selection and slave/master muxing from the current grant
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = (m0_cyc && m1_cyc) ? (last_gnt ? GNT0 : GNT1) :
                                m0_cyc ? GNT0 : m1_cyc ? GNT1 : IDLE;
            GNT0:    state_nx = m0_cyc ? GNT0 : IDLE;
            GNT1:    state_nx = m1_cyc ? GNT1 : IDLE;
            default: state_nx = IDLE;
        endcase
        s_cyc   = g0 ? m0_cyc : g1 ? m1_cyc : 1'b0;
        s_stb   = g_stb && !expire;
        s_we    = g0 ? m0_we : g1 ? m1_we : 1'b0;
        s_adr   = g0 ? m0_adr : g1 ? m1_adr : '0;
        s_dat_w = g0 ? m0_dat_w : g1 ? m1_dat_w : '0;
        s_sel   = g0 ? m0_sel : g1 ? m1_sel : '0;
        m0_ack  = g0 && s_ack;
        m1_ack  = g1 && s_ack;
        m0_err  = g0 && (s_err || expire);
        m1_err  = g1 && (s_err || expire);
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed checks of grant, muxing, release, reset and watchdog behaviour
module tb_wb_bus_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [23:0] m0_adr = '0;
    logic [15:0] m0_dat_w = '0;
    logic [1:0]  m0_sel = '0;
    logic [15:0] m0_dat_r;
    logic        m0_ack, m0_err;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [23:0] m1_adr = '0;
    logic [15:0] m1_dat_w = '0;
    logic [1:0]  m1_sel = '0;
    logic [15:0] m1_dat_r;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [23:0] s_adr;
    logic [15:0] s_dat_w;
    logic [1:0]  s_sel;
    logic [15:0] s_dat_r = '0;
    logic        s_ack = 0, s_err = 0;
    logic [1:0]  o_gnt;
    logic        o_timeout;
    int n_cmp = 0;
    int n_err = 0;

    wb_bus_arbiter #(.TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .o_gnt(o_gnt), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int hits;
        #12;
        chk("rst_gnt", o_gnt, 2'b00);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_timeout", o_timeout, 0);
        tick();
        i_rst = 1'b1;
        tick();
        // single master read at 0x002008, slave acks on the 2nd granted cycle
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 24'h002008; m0_sel = 2'b11;
        chk("t1_idle_gnt", o_gnt, 2'b00);
        chk("t1_idle_stb", s_stb, 0);
        chk("t1_idle_adr", s_adr, 0);
        tick();
        chk("t1_gnt", o_gnt, 2'b01);
        chk("t1_adr", s_adr, 24'h002008);
        chk("t1_stb", s_stb, 1);
        chk("t1_no_ack", m0_ack, 0);
        tick();
        s_ack = 1; s_dat_r = 16'h1234;
        #1;
        chk("t1_ack", m0_ack, 1);
        chk("t1_dat", m0_dat_r, 16'h1234);
        chk("t1_m1_ack", m1_ack, 0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("t1_ack_once", m0_ack, 0);
        tick();
        chk("t1_release", o_gnt, 2'b00);
        // burst hold: m1 keeps cyc for 3 stb/ack pairs while m0 waits
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 24'h000040; m1_dat_w = 16'hBEEF; m1_sel = 2'b01;
        tick();
        m0_cyc = 1; m0_stb = 1;
        #1;
        chk("bh_gnt", o_gnt, 2'b10);
        chk("bh_adr", s_adr, 24'h000040);
        chk("bh_dat_w", s_dat_w, 16'hBEEF);
        chk("bh_we", s_we, 1);
        chk("bh_sel", s_sel, 2'b01);
        for (int i = 0; i < 3; i++) begin
            m1_stb = 1; s_ack = 1;
            #1;
            chk("bh_m1_ack", m1_ack, 1);
            chk("bh_m0_ack", m0_ack, 0);
            tick();
            s_ack = 0; m1_stb = 0;
            #1;
            chk("bh_stb_low", s_stb, 0);
            chk("bh_hold", o_gnt, 2'b10);
            tick();
        end
        m1_cyc = 0;
        #1;
        chk("bh_drop_gnt", o_gnt, 2'b10);
        tick();
        chk("bh_turnaround", o_gnt, 2'b00);
        tick();
        chk("bh_m0_gnt", o_gnt, 2'b01);
        chk("bh_m0_adr", s_adr, 24'h002008);
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("bh_idle", o_gnt, 2'b00);
        // asynchronous reset while m1 owns the bus
        m1_cyc = 1; m1_stb = 1;
        tick();
        chk("ar_gnt", o_gnt, 2'b10);
        chk("ar_s_cyc", s_cyc, 1);
        s_ack = 1;
        #1;
        chk("ar_ack", m1_ack, 1);
        #2;
        i_rst = 0;
        #1;
        chk("ar_gnt_drop", o_gnt, 2'b00);
        chk("ar_s_cyc_drop", s_cyc, 0);
        chk("ar_s_stb_drop", s_stb, 0);
        chk("ar_no_ack", m1_ack, 0);
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        tick();
        i_rst = 1;
        // contention: both request in the same idle cycle, grants alternate
        m0_cyc = 1; m0_stb = 1; m0_adr = 24'h000100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 24'h000200;
        #1;
        chk("ct_idle0", o_gnt, 2'b00);
        tick();
        s_ack = 1;
        #1;
        chk("ct_gnt0", o_gnt, 2'b01);
        chk("ct_adr0", s_adr, 24'h000100);
        chk("ct_m0_ack", m0_ack, 1);
        chk("ct_m1_wait", m1_ack, 0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("ct_gnt0_drop", o_gnt, 2'b01);
        chk("ct_s_cyc_low", s_cyc, 0);
        tick();
        chk("ct_idle1", o_gnt, 2'b00);
        m0_cyc = 1; m0_stb = 1;
        tick();
        s_ack = 1;
        #1;
        chk("ct_gnt1", o_gnt, 2'b10);
        chk("ct_adr1", s_adr, 24'h000200);
        chk("ct_m1_ack", m1_ack, 1);
        chk("ct_m0_wait", m0_ack, 0);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        chk("ct_idle2", o_gnt, 2'b00);
        m1_cyc = 1; m1_stb = 1;
        tick();
        chk("ct_gnt0_again", o_gnt, 2'b01);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        chk("ct_idle3", o_gnt, 2'b00);
        // watchdog: m0 strobes 0x002030 and the slave never answers
        m0_cyc = 1; m0_stb = 1; m0_adr = 24'h002030;
        tick();
`ifdef WB_BUS_ARBITER_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            chk("to_quiet_err", m0_err, 0);
            chk("to_quiet_pulse", o_timeout, 0);
            chk("to_quiet_stb", s_stb, 1);
            tick();
        end
        chk("to_err", m0_err, 1);
        chk("to_pulse", o_timeout, 1);
        chk("to_stb_forced", s_stb, 0);
        chk("to_m1_err", m1_err, 0);
        tick();
        chk("to_err_once", m0_err, 0);
        chk("to_pulse_once", o_timeout, 0);
        chk("to_gnt_kept", o_gnt, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        tick();
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 1; k < 8; k++) tick();
        s_ack = 1;
        #1;
        chk("race_ack", m0_ack, 1);
        chk("race_err", m0_err, 0);
        chk("race_pulse", o_timeout, 0);
        tick();
        s_ack = 0;
`else
        hits = 0;
        for (int k = 0; k < 1000; k++) begin
            if (m0_err || o_timeout || !s_stb) hits++;
            tick();
        end
        chk("hang_no_err", hits, 0);
        chk("hang_gnt", o_gnt, 2'b01);
`endif
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();
        chk("end_idle", o_gnt, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the SoC peripheral bus (16-bit data, 24-bit address, 2 select bits).
- Master 0 is the CPU bus bridge (cw bus decompressor output); master 1 is a secondary master (DMA / debug loader).
- The single slave side feeds the existing address decode / peripheral mux unchanged.
- Grants round-robin per bus cycle; ownership is held for the whole cyc; optional watchdog terminates hung transfers with err.

Parameters:
- ADDR_W, 24, Wishbone address width.
- DATA_W, 16, Wishbone data width.
- SEL_W, 2, byte-select width.
- TIMEOUT, 255, watchdog limit in cycles of stb without ack/err (optional feature only); legal range 2..65535.

Ports:
- i_clk  in  1  bus clock (cw_clk domain)
- i_rst  in  1  asynchronous active-low reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 control
- m0_adr  in  ADDR_W  master 0 address
- m0_dat_w  in  DATA_W  master 0 write data
- m0_sel  in  SEL_W  master 0 byte select
- m0_dat_r  out  DATA_W  read data to master 0
- m0_ack, m0_err  out  1 each  master 0 termination
- m1_*  same set as m0_*, for master 1
- s_cyc, s_stb, s_we  out  1 each  slave control
- s_adr  out  ADDR_W  slave address
- s_dat_w  out  DATA_W  slave write data
- s_sel  out  SEL_W  slave byte select
- s_dat_r  in  DATA_W  slave read data
- s_ack, s_err  in  1 each  slave termination
- o_gnt  out  2  one-hot current grant (00 = idle)
- o_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (i_rst low, async): state IDLE, o_gnt=00, last_gnt=1, o_timeout=0, watchdog count=0. All s_* control outputs and m*_ack/err read 0 combinationally.
- States:
  - IDLE: o_gnt=00; s_cyc=s_stb=0; s_adr, s_dat_w, s_sel, s_we driven 0.
  - GNT0 / GNT1: slave outputs are a combinational mux from the granted master.
- IDLE transitions on each edge:
  - Only m0_cyc high -> GNT0.
  - Only m1_cyc high -> GNT1.
  - Both high -> grant the master other than last_gnt. After reset this means m0 wins first.
  - last_gnt updates on entry to GNT0/GNT1.
- Grant latency: a request seen in IDLE reaches the slave on the next cycle. The master must hold cyc/stb until acked (standard Wishbone).
- In GNTx:
  - s_cyc=mx_cyc, s_stb=mx_stb.
  - mx_ack=s_ack, mx_err=s_err (combinational).
  - Ungranted master: ack=err=0; its stb is ignored and it waits.
- m0_dat_r and m1_dat_r are both driven from s_dat_r. Only the granted master's ack qualifies the data.
- Release: when the granted mx_cyc is sampled low -> IDLE. The next grant therefore needs one idle cycle (turnaround). No preemption while cyc is held; back-to-back stb pulses within one cyc stay with the same master.
- Simultaneous cyc drop and other-master request: go to IDLE first, then grant the other master next cycle.
- A pending master is never starved: after a cyc from master x completes, a waiting master y is granted before x again.
- Reset asserted mid-transfer: grant drops immediately (async) and no ack is forwarded. Masters are responsible for abandoning the cycle.

Optional Feature:
- Macro: WB_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - Counter (16-bit, saturating at TIMEOUT) increments each cycle the granted stb is high with s_ack=s_err=0.
  - Counter clears on ack, err, stb low, or grant change.
  - When the count equals TIMEOUT-1 and no ack/err arrives that cycle: the granted master receives err for exactly one cycle, o_timeout pulses, s_stb is forced 0 in that cycle, and the counter clears. The grant is kept until that master drops cyc.
  - A real s_ack in the expiry cycle wins: no err, no pulse.
- Undefined: no counter logic; o_timeout tied 0; a hung slave stalls the bus indefinitely.

Test Plan:
- Single master: after reset, m0 does a read at 0x002008 with slave acking the 2nd cycle, s_dat_r=0x1234 -> o_gnt=01 one cycle after m0_cyc, m0_ack pulses once, m0_dat_r=0x1234, m1_ack stays 0.
- Contention: m0 and m1 both raise cyc in the same IDLE cycle and both hold requests -> grants are GNT0, IDLE, GNT1, IDLE, GNT0 (alternating), each separated by exactly one idle cycle.
- Burst hold: m1 holds cyc across 3 stb/ack pairs while m0 requests -> m0 is not granted until m1_cyc falls; all 3 acks go to m1 only.
- Timeout (WB_BUS_ARBITER_TIMEOUT_EN, TIMEOUT=8): m0 strobes 0x002030 and the slave never acks -> m0_err high at the 8th stb cycle, o_timeout pulses once, s_stb=0 that cycle. With the macro undefined, no err appears in 1000 cycles.
- Timeout race: slave acks exactly at cycle TIMEOUT -> m0_ack=1, m0_err=0, o_timeout=0.
- Async reset: drop i_rst mid-transfer while in GNT1 -> o_gnt=00 and s_cyc=0 immediately without a clock edge. After release, the first simultaneous request is granted to m0.
